// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Optional watchdog abort in WAIT_END is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 send_pulse,
    output logic [7:0]           byte_out,
    input  logic                 byte_end,
    output logic                 busy,
    output logic                 err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_START    = 2'd1;
    localparam logic [1:0] S_WAIT_END = 2'd2;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES <= 352) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must exceed one full frame (352 clk)");
    end

    logic [1:0]         state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   owner_next;

    logic               found;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] win_onehot;
    int                 cand;

    // Search ptr, ptr+1, ... wrapping; the first asserted request wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found   = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    assign owner_next = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wdog;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            send_pulse <= 1'b0;
            byte_out   <= 8'h00;
            busy       <= 1'b0;
            err        <= 1'b0;
            wdog       <= '0;
        end else begin
            done       <= '0;
            send_pulse <= 1'b0;
            err        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant      <= win_onehot;
                        owner      <= win_idx;
                        byte_out   <= req_data[8*int'(win_idx) +: 8];
                        busy       <= 1'b1;
                        send_pulse <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    // A byte_end on the expiry edge still completes normally.
                    if (byte_end) begin
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                        state <= S_IDLE;
                    end else if (wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        ptr   <= owner_next;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign err = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ptr        <= '0;
            owner      <= '0;
            grant      <= '0;
            done       <= '0;
            send_pulse <= 1'b0;
            byte_out   <= 8'h00;
            busy       <= 1'b0;
        end else begin
            done       <= '0;
            send_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        grant      <= win_onehot;
                        owner      <= win_idx;
                        byte_out   <= req_data[8*int'(win_idx) +: 8];
                        busy       <= 1'b1;
                        send_pulse <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT_END;
                end
                S_WAIT_END: begin
                    if (byte_end) begin
                        done  <= grant;
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_sm_tx byte transmitter between NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's byte, issues a single-cycle send_pulse, and holds byte_out stable for the whole frame.
- Waits for byte_end, then acknowledges the owner with a one-cycle done pulse.
- Sits between CPU-side producers (debug/console/status sources) and the UART TX state machine.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 512, WAIT_END watchdog limit in clk cycles. Used only with UART_ARB_TIMEOUT_EN; must exceed 352 (11 bits x 32 clk).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester transmit request, level
- req_data  input  8*NUM_REQ  byte for requester i at bits [8i+7:8i]
- done  output  NUM_REQ  one-hot, one-cycle pulse when requester's byte has fully left the UART
- grant  output  NUM_REQ  one-hot current owner; 0 when idle
- send_pulse  output  1  to uart_sm_tx send_pulse; one-cycle pulse
- byte_out  output  8  to uart_sm_tx byte_in; stable from send_pulse until byte_end
- byte_end  input  1  from uart_sm_tx byte_end
- busy  output  1  high while a byte is owned (START or WAIT_END)
- err  output  1  one-cycle pulse on watchdog abort (0 if feature off)

Behaviour:
- All outputs are registered.
- Reset: state=IDLE, ptr=0, grant=0, done=0, send_pulse=0, byte_out=8'h00, busy=0, err=0, watchdog counter=0. Reset mid-frame aborts silently with no done; requesters must keep or re-raise req.
- States: IDLE, START, WAIT_END.
- IDLE:
  - If req!=0, pick the winner w = first set bit searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - At that edge: grant<=onehot(w), byte_out<=req_data[w], busy<=1, send_pulse<=1, state<=START.
  - If req==0, stay in IDLE.
- START: lasts exactly one cycle, with send_pulse high. At exit: send_pulse<=0, state<=WAIT_END, watchdog cleared.
- WAIT_END: on byte_end=1 at an edge:
  - done<=grant, grant<=0, busy<=0, ptr<=(w+1) mod NUM_REQ, state<=IDLE.
  - done is high for exactly the next cycle.
- Latency:
  - req sampled at edge k in IDLE: send_pulse is high in cycle k+1.
  - byte_end sampled at edge m: done is high in cycle m+1.
  - Earliest next send_pulse is cycle m+2. This guarantees uart_sm_tx has already returned to its IDLE.
- Handshake rules:
  - Requester holds req high until it sees its done bit. Data is captured at grant, so req_data may change after grant.
  - A requester re-asserting req in the done cycle is sampled normally. It has lowest priority because ptr has just moved past it.
- byte_end in IDLE or START is ignored.
- req dropping while owned does not abort the frame; done is still issued.
- ptr width is clog2(NUM_REQ); ptr wraps from NUM_REQ-1 to 0.
- A requester is never starved: with all req high, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - In WAIT_END a counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1 without byte_end: state<=IDLE, grant<=0, busy<=0, err<=1 for one cycle, no done, ptr advanced past the owner.
  - byte_end on that same edge takes precedence, giving a normal completion.
- Not defined: no counter logic; err tied to 0; the arbiter waits for byte_end indefinitely.

Test Plan:
- Single request, with uart_sm_tx attached: req=4'b0010, data1=8'hA5 -> send_pulse high one cycle after req is sampled. TX line: start 0 then bits 1,0,1,0,0,1,0,1 then stop 1, 32 clk each. done=4'b0010 one cycle after byte_end. grant=0 afterwards.
- All four requesting, data 8'h10..8'h13 -> bytes 10,11,12,13 in that order. ptr wraps so a fifth request from req0 is served next. Each done is a single one-hot pulse.
- req0 held continuously while req2 rises mid-frame -> after req0's done, req2 wins the next grant (ptr=1 skips the idle req1), then req0.
- Change req_data of the owner after grant -> byte_out is unchanged until done; the transmitted byte equals the value captured at grant.
- Reset asserted in WAIT_END mid-byte -> all outputs 0 the next cycle, no done; re-raised req restarts from ptr=0.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=512, byte_end stuck 0 -> err pulses once 512 cycles after entering WAIT_END, no done, grant=0. Next requester is then served. Without the macro, busy stays high.
